sobel_window_gen: RTL

//  Parametrised KxK sliding-window generator; successor to the fixed 3x3 line-buffer/window pair.

---
 rtl/sobel_window_gen_pkg.sv | 22 ++
 rtl/sobel_window_gen_if.sv | 15 +
 rtl/sobel_window_gen_line_buffer_ram.sv | 25 ++
 rtl/sobel_window_gen.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sobel_window_gen_pkg.sv
// Shared constants, FSM encoding and sizing helper for the KxK window generator.
package sobel_window_gen_pkg;

  localparam int unsigned BORDER_VALID = 0;
  localparam int unsigned BORDER_ZERO  = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAD_COL = 2'd2,
    ST_PAD_ROW = 2'd3
  } state_e;

  // Bits needed to count 0..v-1, never less than 1.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out bundle between the converter, window generator and kernel.
interface sobel_window_gen_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned KSIZE  = 3
);
  logic                            done_i;
  logic [DATA_W-1:0]               data_i;
  logic                            ready_o;
  logic [KSIZE*KSIZE*DATA_W-1:0]   window_o;
  logic                            done_o;
  logic                            frame_done_o;

  modport master (output done_i, data_i, input ready_o, window_o, done_o, frame_done_o);
  modport slave  (input done_i, data_i, output ready_o, window_o, done_o, frame_done_o);
endinterface

// File: rtl/sobel_window_gen_line_buffer_ram.sv
// One-line delay: reading address a returns what was written at a one line earlier.
module line_buffer_ram
  import sobel_window_gen_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 400,
  localparam int unsigned AW     = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the new sample; the read port still shows the old one this cycle.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// KxK sliding-window generator over a raster stream, VALID or zero-padded borders.
module sobel_window_gen
  import sobel_window_gen_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ROWS        = 400,
  parameter int unsigned COLS        = 400,
  parameter int unsigned KSIZE       = 3,
  parameter int unsigned BORDER_MODE = BORDER_VALID
) (
  input logic               clk,
  input logic               rst,
  sobel_window_gen_if.slave bus
);

  localparam int unsigned H        = (KSIZE - 1) / 2;
  localparam int unsigned E        = (BORDER_MODE == BORDER_ZERO) ? H : 0;
  localparam int unsigned VR       = ROWS + E;
  localparam int unsigned VC       = COLS + E;
  localparam int unsigned VR_W     = clog2_min1(VR);
  localparam int unsigned VC_W     = clog2_min1(VC);
  localparam int unsigned AW       = clog2_min1(COLS);
  localparam int unsigned EMIT_MIN = (BORDER_MODE == BORDER_ZERO) ? H : KSIZE - 1;
  localparam int unsigned WIN_W    = KSIZE * KSIZE * DATA_W;

  state_e              state_q, state_n;
  logic [VR_W-1:0]     vr_q, vr_n;
  logic [VC_W-1:0]     vc_q, vc_n;
  logic                ready_q, ready_n;
  logic                done_q, frame_done_q;
  logic [WIN_W-1:0]    window_q, win_next;
  logic [DATA_W-1:0]   hist_q [KSIZE][KSIZE-1];
  logic [DATA_W-1:0]   col    [KSIZE];
  logic [DATA_W-1:0]   lb_rd  [KSIZE-1];
  logic [DATA_W-1:0]   lb_wr  [KSIZE-1];
  logic                accept, virt, col_virt, advance, emit, last_pos, lb_we;

  assign accept   = bus.done_i & ready_q;
  assign virt     = (state_q == ST_PAD_COL) || (state_q == ST_PAD_ROW);
  assign advance  = accept | virt;
  assign col_virt = int'(vc_q) >= int'(COLS);
  assign lb_we    = advance & ~col_virt;
  assign last_pos = (int'(vr_q) == int'(VR) - 1) && (int'(vc_q) == int'(VC) - 1);
  assign emit     = advance && (int'(vr_q) >= int'(EMIT_MIN)) && (int'(vc_q) >= int'(EMIT_MIN));

  // Incoming column: current pixel at the bottom, older lines above; virtual taps are zero.
  always_comb begin
    for (int r = 0; r < int'(KSIZE); r++) col[r] = '0;
    for (int i = 0; i < int'(KSIZE) - 1; i++) lb_wr[i] = '0;
    col[KSIZE-1] = virt ? '0 : bus.data_i;
    for (int i = 0; i < int'(KSIZE) - 1; i++) begin
      col[int'(KSIZE) - 2 - i] = col_virt ? '0 : lb_rd[i];
      lb_wr[i] = (i == 0) ? col[KSIZE-1] : lb_rd[i-1];
    end
  end

  for (genvar g = 0; g < int'(KSIZE) - 1; g++) begin : g_lb
    line_buffer_ram #(.DATA_W(DATA_W), .DEPTH(COLS)) u_lb (
      .clk   (clk),
      .we    (lb_we),
      .addr  (AW'(vc_q)),
      .wdata (lb_wr[g]),
      .rdata (lb_rd[g])
    );
  end

  // Assemble the window being entered this cycle; in ZERO mode mask taps above/left of the frame.
  always_comb begin
    logic [DATA_W-1:0] tap;
    win_next = '0;
    for (int r = 0; r < int'(KSIZE); r++) begin
      for (int c = 0; c < int'(KSIZE); c++) begin
        tap = (c == int'(KSIZE) - 1) ? col[r] : hist_q[r][(c < int'(KSIZE) - 1) ? c : 0];
        if ((BORDER_MODE == BORDER_ZERO) &&
            ((int'(vr_q) + r < int'(KSIZE) - 1) || (int'(vc_q) + c < int'(KSIZE) - 1)))
          tap = '0;
        win_next[(r * int'(KSIZE) + c) * int'(DATA_W) +: DATA_W] = tap;
      end
    end
  end

  // Scan state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vr_q    <= '0;
      vc_q    <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_n;
      vr_q    <= vr_n;
      vc_q    <= vc_n;
      ready_q <= ready_n;
    end
  end

  // Next scan position over the virtual grid and the registered ready it implies.
  always_comb begin
    state_n = state_q;
    vr_n    = vr_q;
    vc_n    = vc_q;
    if (advance) begin
      unique case (state_q)
        ST_IDLE, ST_RUN: begin
          if (int'(vc_q) == int'(COLS) - 1) begin
            if (E != 0) begin
              state_n = ST_PAD_COL;
              vc_n    = vc_q + VC_W'(1);
            end else begin
              vc_n = '0;
              if (int'(vr_q) == int'(ROWS) - 1) begin
                state_n = ST_IDLE;
                vr_n    = '0;
              end else begin
                state_n = ST_RUN;
                vr_n    = vr_q + VR_W'(1);
              end
            end
          end else begin
            state_n = ST_RUN;
            vc_n    = vc_q + VC_W'(1);
          end
        end
        ST_PAD_COL: begin
          if (int'(vc_q) == int'(VC) - 1) begin
            vc_n    = '0;
            vr_n    = vr_q + VR_W'(1);
            state_n = (int'(vr_q) == int'(ROWS) - 1) ? ST_PAD_ROW : ST_RUN;
          end else begin
            vc_n = vc_q + VC_W'(1);
          end
        end
        ST_PAD_ROW: begin
          if (int'(vc_q) == int'(VC) - 1) begin
            vc_n = '0;
            if (int'(vr_q) == int'(VR) - 1) begin
              state_n = ST_IDLE;
              vr_n    = '0;
            end else begin
              vr_n = vr_q + VR_W'(1);
            end
          end else begin
            vc_n = vc_q + VC_W'(1);
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
    ready_n = (state_n == ST_IDLE) || (state_n == ST_RUN);
  end

  // Column history shift and registered window/strobe outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < int'(KSIZE); r++)
        for (int c = 0; c < int'(KSIZE) - 1; c++) hist_q[r][c] <= '0;
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
      window_q     <= '0;
    end else begin
      if (advance) begin
        for (int r = 0; r < int'(KSIZE); r++) begin
          for (int c = 0; c < int'(KSIZE) - 2; c++) hist_q[r][c] <= hist_q[r][c+1];
          hist_q[r][KSIZE-2] <= col[r];
        end
      end
      done_q       <= emit;
      frame_done_q <= emit & last_pos;
      if (emit) window_q <= win_next;
    end
  end

  assign bus.ready_o      = ready_q;
  assign bus.done_o       = done_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.window_o     = window_q;

endmodule
